coproc_scheduler: RTL
=====================

# coproc_scheduler

Round-robin scheduler that shares one external multiplier and one external adder between NREQ requesters on the coprocessor FPGA. Each requester posts an operand with a toggle-tag handshake. The block arbitrates among pending requesters and sequences the shared datapath through the fixed computation ((x*x)+ADD_K)^2. It returns the result with a response-tag toggle. It sits between the PIC32 port capture logic and the add/mul datapath, replacing the single-channel state machine.

## Interface
- NREQ, 2, number of requesters (2..4)
- W, 8, operand/result width
- ADD_K, 3, constant added in the ADD step
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_data  in  NREQ*W  operand per requester; slice i = [i*W +: W]
- req_tag  in  NREQ  request tag per requester; a toggle posts a request
- rsp_data  out  NREQ*W  result per requester; holds until that requester's next result
- rsp_tag  out  NREQ  response tag; toggles when rsp_data slice is valid
- busy  out  1  high while a job occupies the datapath
- grant_id  out  $clog2(NREQ)  requester currently or last served
- mul_a, mul_b  out  W  multiplier operands; 0 when unused
- mul_result  in  W  combinational product, low W bits
- add_a, add_b  out  W  adder operands; 0 when unused
- add_result  in  W  combinational sum, low W bits

## Operation
- Requester i is pending when req_tag_v[i] != seen_tag[i]. req_tag_v is the (optionally synchronized) tag.
- Requester protocol: hold req_data stable from the tag toggle until rsp_tag[i] == req_tag[i]. Do not toggle again before the response. A double toggle cancels itself and is not detected.
- FSM states: IDLE, SQ1, ADD, SQ2.
- IDLE: if any requester is pending:
  - pick the first pending requester at or after rr_ptr (wrapping);
  - latch its req_data into op, set grant_id, set seen_tag[g] = req_tag_v[g];
  - busy=1; go to SQ1.
  - Otherwise stay in IDLE with busy=0.
- SQ1: mul_a=mul_b=op; r_acc <= mul_result; go to ADD.
- ADD: add_a=r_acc, add_b=ADD_K; r_acc <= add_result; go to SQ2.
- SQ2: mul_a=mul_b=r_acc; rsp_data[g] <= mul_result; rsp_tag[g] toggles; rr_ptr <= g+1 mod NREQ; go to IDLE.
- All arithmetic is modulo 2^W with no saturation. The external units return the low W bits.
- Requests arriving during a job stay pending and are arbitrated at the next IDLE. Other requesters' rsp_data and rsp_tag are untouched.
- Reset values: FSM=IDLE, seen_tag=0, rsp_tag=0, rsp_data=0, busy=0, grant_id=0, rr_ptr=0, op=r_acc=0. Datapath operand outputs are 0.
- Reset mid-job aborts the job: no rsp_tag toggle. Any requester whose req_tag_v is 1 after reset is pending and is served again.

## Timing
- Grant occurs in the IDLE cycle where pending is seen.
- rsp_tag toggles 3 clock edges after the grant edge. Tag-visible to response is 4 cycles.
- Back-to-back jobs: one IDLE cycle between jobs, so throughput is 1 result per 4 cycles.
- busy rises on the grant edge and falls on the SQ2 edge.
- Datapath operands are driven combinationally from the registered state in SQ1/ADD/SQ2. The external path mul→add must fit one clock.
- Simultaneous pending requesters are served in round-robin order starting at rr_ptr. There is no starvation: worst-case wait is (NREQ-1)*4 cycles.

## Configuration
- COPROC_SYNC_EN defined: each req_tag bit passes through a 2-flop synchronizer (reset to 0) before pending detection. This adds 2 cycles of latency. req_data is sampled only at grant, which is safe under the stable-data rule.
- Not defined: req_tag is used directly and must already be synchronous to clock.

## Structure
- coproc_pkg holds:
  - the FSM state enum (IDLE, SQ1, ADD, SQ2);
  - default NREQ, W, ADD_K;
  - a localparam for the job length (4).
- Sub-module coproc_rr_arbiter: inputs are the pending vector and rr_ptr; outputs are grant one-hot/index and any_pending. It is purely combinational.

## Test plan
- Without COPROC_SYNC_EN: req 0 data 5, toggle tag 0→1 -> rsp_data[0]=16 ((25+3)^2=784 mod 256); rsp_tag[0]=1 exactly 4 cycles later.
- Data 2 on req 1 -> rsp_data[1]=49; rsp_data[0] unchanged.
- Data 255 on req 0 -> 255²=65025 mod 256=1, 1+3=4, 4²=16 -> rsp_data[0]=16 (checks W-bit truncation).
- Both reqs toggle in the same cycle after reset -> req 0 served first; req 1 response 4 cycles after req 0's; busy low for exactly one cycle between jobs.
- req 0 re-requests immediately after each response while req 1 is pending -> grants alternate 0,1,0,1.
- Assert reset_n during ADD -> all outputs return to reset values with no rsp_tag toggle. After release, req_tag still 1, so the job reruns and completes.

Source files
------------

// File: rtl/coproc_pkg.sv
// coproc_pkg: shared types and defaults for the coprocessor scheduler.
// Holds the job FSM encoding, default geometry and a pointer-wrap helper.
package coproc_pkg;

    // Default geometry of the scheduler.
    localparam int unsigned COPROC_NREQ  = 2;
    localparam int unsigned COPROC_W     = 8;
    localparam int unsigned COPROC_ADD_K = 3;

    // Clock cycles per job, including the arbitration cycle in IDLE.
    localparam int unsigned JOB_LEN = 4;

    // Job sequencer states: arbitrate, square, add constant, square again.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ1  = 2'd1,
        ADD  = 2'd2,
        SQ2  = 2'd3
    } coproc_state_e;

    // Increment an index modulo n (n need not be a power of two).
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/coproc_rr_arbiter.sv
// coproc_rr_arbiter: combinational round-robin picker.
// Selects the first pending requester at or after rr_ptr_i, wrapping.
module coproc_rr_arbiter
    import coproc_pkg::*;
#(
    parameter  int unsigned NREQ = COPROC_NREQ,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pending_i,
    input  logic [IW-1:0]   rr_ptr_i,
    output logic [NREQ-1:0] grant_oh_o,
    output logic [IW-1:0]   grant_idx_o,
    output logic            any_pending_o
);

    int unsigned   cand;
    logic [IW-1:0] cand_w;

    // Scan requesters starting at the round-robin pointer; first hit wins.
    always_comb begin
        grant_oh_o    = '0;
        grant_idx_o   = '0;
        any_pending_o = 1'b0;
        cand          = 0;
        cand_w        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(rr_ptr_i) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_w = IW'(cand);
            if (!any_pending_o && pending_i[cand_w]) begin
                any_pending_o       = 1'b1;
                grant_idx_o         = cand_w;
                grant_oh_o[cand_w]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coproc_scheduler.sv
// coproc_scheduler: shares one external multiplier and one adder among
// NREQ toggle-tag requesters, computing ((x*x)+ADD_K)^2 mod 2^W per job.
// Optional build macro COPROC_SYNC_EN inserts a 2-flop synchronizer on
// each req_tag bit ahead of pending detection.
module coproc_scheduler
    import coproc_pkg::*;
#(
    parameter  int unsigned NREQ  = COPROC_NREQ,
    parameter  int unsigned W     = COPROC_W,
    parameter  int unsigned ADD_K = COPROC_ADD_K,
    localparam int unsigned IW    = $clog2(NREQ)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ-1:0]   req_tag,
    output logic [NREQ*W-1:0] rsp_data,
    output logic [NREQ-1:0]   rsp_tag,
    output logic              busy,
    output logic [IW-1:0]     grant_id,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [W-1:0]      mul_result,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_result
);

    coproc_state_e     state_q, state_d;

    logic [NREQ-1:0]   req_tag_v;
    logic [NREQ-1:0]   pending;
    logic [NREQ-1:0]   seen_tag_q, seen_tag_d;

    logic [NREQ-1:0]   arb_oh;
    logic [IW-1:0]     arb_idx;
    logic              any_pending;

    logic [W-1:0]      op_q, op_d;
    logic [W-1:0]      r_acc_q, r_acc_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NREQ*W-1:0] rsp_data_q, rsp_data_d;
    logic [NREQ-1:0]   rsp_tag_q, rsp_tag_d;

`ifdef COPROC_SYNC_EN
    logic [NREQ-1:0]   sync1_q, sync2_q;

    // Two-flop synchronizer bringing asynchronous request tags into clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req_tag;
            sync2_q <= sync1_q;
        end
    end

    assign req_tag_v = sync2_q;
`else
    assign req_tag_v = req_tag;
`endif

    // A requester is pending while its tag differs from the last one accepted.
    assign pending = req_tag_v ^ seen_tag_q;

    coproc_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .pending_i     (pending),
        .rr_ptr_i      (rr_ptr_q),
        .grant_oh_o    (arb_oh),
        .grant_idx_o   (arb_idx),
        .any_pending_o (any_pending)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a job always runs SQ1 -> ADD -> SQ2 once granted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = any_pending ? SQ1 : IDLE;
            SQ1:     state_d = ADD;
            ADD:     state_d = SQ2;
            SQ2:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: drive the shared datapath only in the step that uses it.
    always_comb begin
        busy  = (state_q != IDLE);
        mul_a = '0;
        mul_b = '0;
        add_a = '0;
        add_b = '0;
        unique case (state_q)
            SQ1: begin
                mul_a = op_q;
                mul_b = op_q;
            end
            ADD: begin
                add_a = r_acc_q;
                add_b = W'(ADD_K);
            end
            SQ2: begin
                mul_a = r_acc_q;
                mul_b = r_acc_q;
            end
            default: ;
        endcase
    end

    // Datapath next state: grant capture, accumulate, and result write-back.
    always_comb begin
        seen_tag_d = seen_tag_q;
        op_d       = op_q;
        r_acc_d    = r_acc_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        unique case (state_q)
            IDLE: begin
                if (any_pending) begin
                    grant_d = arb_idx;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (arb_oh[i]) begin
                            op_d          = req_data[i*W +: W];
                            seen_tag_d[i] = req_tag_v[i];
                        end
                    end
                end
            end
            SQ1: r_acc_d = mul_result;
            ADD: r_acc_d = add_result;
            SQ2: begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (grant_q == IW'(i)) begin
                        rsp_data_d[i*W +: W] = mul_result;
                        rsp_tag_d[i]         = ~rsp_tag_q[i];
                    end
                end
                rr_ptr_d = IW'(wrap_inc(32'(grant_q), NREQ));
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any job in flight without a response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seen_tag_q <= '0;
            op_q       <= '0;
            r_acc_q    <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
        end else begin
            seen_tag_q <= seen_tag_d;
            op_q       <= op_d;
            r_acc_q    <= r_acc_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
        end
    end

    assign grant_id = grant_q;
    assign rsp_data = rsp_data_q;
    assign rsp_tag  = rsp_tag_q;

endmodule
